// File: rtl/c2_window_read.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// c2_window_read
//
// Read-side address generator for the pooling-1 output memory. The memory
// holds a MAP_W x MAP_W feature map stored row-major. The block sweeps every
// K x K convolution window in raster order (OUT_W x OUT_W windows). For each
// tap it presents the feature-map read address and the matching weight index.
// Valid and framing strobes are delayed by RD_LAT cycles, so they line up with
// the memory read data for the conv-2 multiply-accumulate stage.
//
// All state updates happen on the falling edge of clk.
//
// Ports
//   clk        clock, falling edge active
//   reset      synchronous, active-low reset
//   enable     level; high lets the sweep issue taps, low pauses it
//   stall      downstream back-pressure; high blocks the issue in this cycle
//   addr       feature-map read address of the tap about to issue
//   waddr      weight index kr*K+kc of the tap about to issue
//   tap_valid  read data for an earlier issued addr is valid in this cycle
//   win_first  with tap_valid: tap (0,0) of a window
//   win_last   with tap_valid: tap (K-1,K-1) of a window
//   out_row    window row, aligned with tap_valid
//   out_col    window column, aligned with tap_valid
//   done       sweep complete; sticky until reset
// ---------------------------------------------------------------------------
module c2_window_read #(
  parameter int MAP_W  = 12,
  parameter int K      = 5,
  parameter int OUT_W  = 8,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              stall,
  output logic [ADDR_W-1:0] addr,
  output logic [4:0]        waddr,
  output logic              tap_valid,
  output logic              win_first,
  output logic              win_last,
  output logic [2:0]        out_row,
  output logic [2:0]        out_col,
  output logic              done
);

  localparam logic [2:0]        KMAX      = 3'(K - 1);
  localparam logic [2:0]        OMAX      = 3'(OUT_W - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(MAP_W);
  // From the last window of a row, base must reach the first window of the
  // next row: (OUT_W-1) + K == MAP_W, so adding K finishes the jump.
  localparam logic [ADDR_W-1:0] ROW_JUMP  = ADDR_W'(K);
  localparam logic [1:0]        DRAIN_END = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;
  logic [1:0] drain_cnt;

  // Window / kernel counters. base and row_off are maintained incrementally
  // so the address needs only adders.
  logic [2:0]        kc;
  logic [2:0]        kr;
  logic [2:0]        ocol;
  logic [2:0]        orow;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] row_off;
  logic [4:0]        widx;

  logic issue;
  logic last_tap;
  logic tap_first;
  logic tap_last;

  // Delay line matching the memory read latency
  logic       vld_p   [RD_LAT];
  logic       first_p [RD_LAT];
  logic       last_p  [RD_LAT];
  logic [2:0] row_p   [RD_LAT];
  logic [2:0] col_p   [RD_LAT];

  assign issue     = (state == RUN) & enable & ~stall;
  assign tap_first = (kc == 3'd0) & (kr == 3'd0);
  assign tap_last  = (kc == KMAX) & (kr == KMAX);
  assign last_tap  = tap_last & (ocol == OMAX) & (orow == OMAX);

  // ---- FSM --------------------------------------------------------------
  always_ff @(negedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable) state_nx = RUN;
      RUN:     if (issue && last_tap) state_nx = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_END) state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Counts the cycles spent in DRAIN so DONE follows the last tap_valid.
  always_ff @(negedge clk) begin
    if (!reset || state != DRAIN) begin
      drain_cnt <= 2'd0;
    end else begin
      drain_cnt <= drain_cnt + 2'd1;
    end
  end

  // ---- issue stage: counter advance -------------------------------------
  // The final tap leaves every counter untouched, so addr/waddr keep showing
  // it while the FSM drains.
  always_ff @(negedge clk) begin
    if (!reset) begin
      kc      <= 3'd0;
      kr      <= 3'd0;
      ocol    <= 3'd0;
      orow    <= 3'd0;
      base    <= '0;
      row_off <= '0;
      widx    <= 5'd0;
    end else if (issue && !last_tap) begin
      if (kc != KMAX) begin
        kc   <= kc + 3'd1;
        widx <= widx + 5'd1;
      end else begin
        kc <= 3'd0;
        if (kr != KMAX) begin
          kr      <= kr + 3'd1;
          row_off <= row_off + ROW_STEP;
          widx    <= widx + 5'd1;
        end else begin
          kr      <= 3'd0;
          row_off <= '0;
          widx    <= 5'd0;
          if (ocol != OMAX) begin
            ocol <= ocol + 3'd1;
            base <= base + {{(ADDR_W-1){1'b0}}, 1'b1};
          end else begin
            ocol <= 3'd0;
            orow <= orow + 3'd1;
            base <= base + ROW_JUMP;
          end
        end
      end
    end
  end

  assign addr  = base + row_off + ADDR_W'(kc);
  assign waddr = widx;

  // ---- delay stages p0 .. p(RD_LAT-1) -----------------------------------
  // The line shifts every cycle, independent of stall, so taps already sent
  // to the memory always emerge.
  always_ff @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_p[i]   <= 1'b0;
        first_p[i] <= 1'b0;
        last_p[i]  <= 1'b0;
        row_p[i]   <= 3'd0;
        col_p[i]   <= 3'd0;
      end
    end else begin
      vld_p[0]   <= issue;
      first_p[0] <= issue & tap_first;
      last_p[0]  <= issue & tap_last;
      row_p[0]   <= orow;
      col_p[0]   <= ocol;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p[i]   <= vld_p[i-1];
        first_p[i] <= first_p[i-1];
        last_p[i]  <= last_p[i-1];
        row_p[i]   <= row_p[i-1];
        col_p[i]   <= col_p[i-1];
      end
    end
  end

  // ---- output stage -----------------------------------------------------
  assign tap_valid = vld_p[RD_LAT-1];
  assign win_first = first_p[RD_LAT-1];
  assign win_last  = last_p[RD_LAT-1];
  assign out_row   = row_p[RD_LAT-1];
  assign out_col   = col_p[RD_LAT-1];
  assign done      = (state == DONE);

endmodule

// File: tb/tb_c2_window_read.sv
`timescale 1ns/1ps
// Bench for c2_window_read: two instances (RD_LAT=1 and RD_LAT=3) share one
// stimulus stream. Per instance, a reference model pushes the expected tap
// for every issue into a queue, and a monitor pops and checks it whenever
// tap_valid is seen. DUT state changes on the falling edge; the bench drives
// and samples around the rising edge.
module tb_c2_window_read;
  localparam int PER = 10;

  logic clk = 1'b0;
  always #(PER/2) clk = ~clk;

  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic st    = 1'b0;
  logic fin   = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [7:0] addr_o  [2];
  logic [4:0] waddr_o [2];
  logic       tv_o    [2];
  logic       wf_o    [2];
  logic       wl_o    [2];
  logic [2:0] row_o   [2];
  logic [2:0] col_o   [2];
  logic       done_o  [2];

  c2_window_read #(.MAP_W(12), .K(5), .OUT_W(8), .RD_LAT(1), .ADDR_W(8)) u_lat1 (
    .clk(clk), .reset(rst_n), .enable(en), .stall(st),
    .addr(addr_o[0]), .waddr(waddr_o[0]), .tap_valid(tv_o[0]),
    .win_first(wf_o[0]), .win_last(wl_o[0]), .out_row(row_o[0]),
    .out_col(col_o[0]), .done(done_o[0])
  );

  c2_window_read #(.MAP_W(12), .K(5), .OUT_W(8), .RD_LAT(3), .ADDR_W(8)) u_lat3 (
    .clk(clk), .reset(rst_n), .enable(en), .stall(st),
    .addr(addr_o[1]), .waddr(waddr_o[1]), .tap_valid(tv_o[1]),
    .win_first(wf_o[1]), .win_last(wl_o[1]), .out_row(row_o[1]),
    .out_col(col_o[1]), .done(done_o[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Hand-computed addresses for selected taps (tap index within the sweep).
  function automatic int dir_addr(input int t);
    case (t)
      0:       return 0;    // window (0,0) first tap
      5:       return 12;   // second kernel row
      24:      return 52;   // window (0,0) last tap
      25:      return 1;    // window (0,1) first tap
      88:      return 30;   // window (0,3) kr=2 kc=3, stall point
      89:      return 31;
      90:      return 39;   // wrap to kernel row 3
      199:     return 59;   // window (0,7) last tap
      200:     return 12;   // window (1,0) first tap
      1599:    return 143;  // final tap
      default: return -1;
    endcase
  endfunction

  function automatic int dir_waddr(input int t);
    case (t)
      0:       return 0;
      5:       return 5;
      24:      return 24;
      25:      return 0;
      88:      return 13;
      89:      return 14;
      90:      return 15;
      199:     return 24;
      200:     return 0;
      1599:    return 24;
      default: return -1;
    endcase
  endfunction

  typedef struct {
    longint due;
    int     row;
    int     col;
    bit     first;
    bit     last;
  } exp_t;

  task automatic cyc(input logic r, input logic e, input logic s);
    @(posedge clk);
    #1;
    rst_n = r;
    en    = e;
    st    = s;
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;
    exp_t q[$];
    int   ms     = 0;   // 0 idle, 1 run, 2 drain, 3 done
    int   t      = 0;
    int   dcnt   = 0;
    int   n_seen = 0;
    int   sweeps = 0;
    bit   armed  = 1'b0;

    // Reference model: checks the issue-side outputs and queues expected taps.
    initial forever begin
      int   ea;
      int   ew;
      int   win;
      int   k;
      exp_t e;
      @(posedge clk);
      #2;
      if (armed) begin
        case (ms)
          0: begin ea = 0; ew = 0; end
          1: begin
            win = t / 25;
            k   = t % 25;
            ea  = (win / 8 + k / 5) * 12 + (win % 8) + (k % 5);
            ew  = k;
          end
          default: begin ea = 143; ew = 24; end
        endcase
        chk($sformatf("lat%0d_addr_st%0d_tap%0d", LAT, ms, t), 32'(addr_o[g]), ea);
        chk($sformatf("lat%0d_waddr_st%0d_tap%0d", LAT, ms, t), 32'(waddr_o[g]), ew);
        chk($sformatf("lat%0d_done_st%0d", LAT, ms), 32'(done_o[g]), 32'(ms == 3));
        if (ms == 0)
          chk($sformatf("lat%0d_idle_outputs", LAT),
              32'({tv_o[g], wf_o[g], wl_o[g], row_o[g], col_o[g]}), 0);
        if (ms == 1 && rst_n && en && !st && dir_addr(t) >= 0) begin
          chk($sformatf("lat%0d_dir_addr_tap%0d", LAT, t), 32'(addr_o[g]), dir_addr(t));
          chk($sformatf("lat%0d_dir_waddr_tap%0d", LAT, t), 32'(waddr_o[g]), dir_waddr(t));
        end
      end
      if (!rst_n) begin
        q.delete();
        ms     = 0;
        t      = 0;
        dcnt   = 0;
        n_seen = 0;
        armed  = 1'b1;
      end else if (armed) begin
        case (ms)
          0: if (en) ms = 1;
          1: if (en && !st) begin
            win     = t / 25;
            k       = t % 25;
            e.due   = longint'($time) - 2 + LAT * PER;
            e.row   = win / 8;
            e.col   = win % 8;
            e.first = (k == 0);
            e.last  = (k == 24);
            q.push_back(e);
            t++;
            if (t == 1600) begin
              ms   = 2;
              dcnt = 0;
            end
          end
          2: begin
            dcnt++;
            if (dcnt == LAT) begin
              ms = 3;
              chk($sformatf("lat%0d_taps_per_sweep", LAT), n_seen, 1600);
              sweeps++;
            end
          end
          default: ;
        endcase
      end
    end

    // Monitor: pops the queue on every tap_valid.
    initial forever begin
      exp_t e;
      @(posedge clk);
      while (q.size() > 0 && q[0].due < longint'($time)) begin
        e = q.pop_front();
        chk($sformatf("lat%0d_tap_missing", LAT), 32'($time), 32'(e.due));
      end
      if (armed && tv_o[g] !== 1'b0) begin
        if (q.size() == 0) begin
          chk($sformatf("lat%0d_spurious_tap_valid", LAT), 32'(tv_o[g]), 0);
        end else begin
          e = q.pop_front();
          chk($sformatf("lat%0d_tap_latency", LAT), 32'($time), 32'(e.due));
          chk($sformatf("lat%0d_tap_fields_r%0dc%0d", LAT, e.row, e.col),
              32'({wf_o[g], wl_o[g], row_o[g], col_o[g]}),
              32'({e.first, e.last, 3'(e.row), 3'(e.col)}));
          n_seen++;
        end
      end
    end

    initial begin
      wait (fin);
      chk($sformatf("lat%0d_completed_sweeps", LAT), sweeps, 2);
      chk($sformatf("lat%0d_queue_left", LAT), q.size(), 0);
    end
  end

  initial begin
    // reset for two cycles
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    // run to window (0,3) tap kr=2 kc=3, stall three cycles there
    repeat (89) cyc(1, 1, 0);
    repeat (3)  cyc(1, 1, 1);
    // continue to tap 700, then reset mid-sweep
    repeat (612) cyc(1, 1, 0);
    cyc(0, 1, 0);
    // full uninterrupted sweep, enable left high in DONE
    repeat (1620) cyc(1, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    // enable toggling every two cycles with periodic stalls
    for (int i = 0; i < 4200; i++) cyc(1, ((i / 2) % 2) == 0, (i % 7) == 3);
    repeat (4) cyc(1, 1, 0);
    fin = 1'b1;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
